// File: rtl/demosaic_pkg.sv
// Shared definitions for the demosaic simulation chain: frame FSM states,
// default VGA 640x480 timing and the Bayer CFA phase encodings used by bayer2rgb.
package demosaic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

  localparam int VGA_H_DISP = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_DISP = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // Phase is {row[0], col[0]}; names give the colour seen for an RGGB sensor.
  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_pattern_t;

  localparam logic [1:0] PHASE_R  = 2'd0;
  localparam logic [1:0] PHASE_GR = 2'd1;
  localparam logic [1:0] PHASE_GB = 2'd2;
  localparam logic [1:0] PHASE_B  = 2'd3;

  function automatic logic [1:0] bayer_phase_of(input logic row0, input logic col0);
    return {row0, col0};
  endfunction

endpackage

// File: rtl/demosaic_frame_ctrl_if.sv
// Control/raster bundle of demosaic_frame_ctrl; frame_cnt/line_cnt exist only
// when DEMOSAIC_FRAME_CTRL_STATS_EN is defined.
interface demosaic_frame_ctrl_if #(
  parameter int H_DISP = demosaic_pkg::VGA_H_DISP,
  parameter int V_DISP = demosaic_pkg::VGA_V_DISP
);
  localparam int XW = $clog2(H_DISP);
  localparam int YW = $clog2(V_DISP);

  logic          start;
  logic          stop;
  logic [15:0]   frame_num;
  logic          busy;
  logic          frame_done;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [1:0]    bayer_phase;
`ifdef DEMOSAIC_FRAME_CTRL_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   line_cnt;
`endif

  modport master (
    output start, stop, frame_num,
    input  busy, frame_done, hsync, vsync, de, pix_x, pix_y, bayer_phase
`ifdef DEMOSAIC_FRAME_CTRL_STATS_EN
    , frame_cnt, line_cnt
`endif
  );

  modport slave (
    input  start, stop, frame_num,
    output busy, frame_done, hsync, vsync, de, pix_x, pix_y, bayer_phase
`ifdef DEMOSAIC_FRAME_CTRL_STATS_EN
    , frame_cnt, line_cnt
`endif
  );

endinterface

// File: rtl/demosaic_frame_ctrl_timing_cnt.sv
// Wrap counter over active + front porch + sync + back porch, with region flags.
module timing_cnt #(
  parameter  int DISP = 640,
  parameter  int FP   = 16,
  parameter  int SYNC = 96,
  parameter  int BP   = 48,
  localparam int TOT  = DISP + FP + SYNC + BP,
  localparam int W    = $clog2(TOT),
  localparam int IW   = $clog2(DISP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [IW-1:0] pos_o,
  output logic          last_o,
  output logic          sync_o,
  output logic          active_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Region compares done in int so a sync region ending exactly at TOT cannot overflow W.
  assign last_o   = (int'(cnt_q) == TOT - 1);
  assign sync_o   = (int'(cnt_q) >= DISP + FP) && (int'(cnt_q) < DISP + FP + SYNC);
  assign active_o = (int'(cnt_q) < DISP);
  assign pos_o    = cnt_q[IW-1:0];

endmodule

// File: rtl/demosaic_frame_ctrl.sv
// Raster frame sequencer (IDLE/RUN/DRAIN) driving hsync/vsync/de, pixel coords and CFA phase.
// Optional statistics outputs enabled by DEMOSAIC_FRAME_CTRL_STATS_EN.
module demosaic_frame_ctrl
  import demosaic_pkg::*;
#(
  parameter int H_DISP = VGA_H_DISP,
  parameter int V_DISP = VGA_V_DISP,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic                  clk,
  input  logic                  rst,
  demosaic_frame_ctrl_if.slave  ctrl_io
);

  localparam int XW = $clog2(H_DISP);
  localparam int YW = $clog2(V_DISP);

  frame_state_t  state_q;
  logic [15:0]   fcnt_q, frame_num_q, fcnt_inc;
  logic          busy_q, frame_done_q, hsync_q, vsync_q, de_q;
  logic [XW-1:0] pix_x_q, pix_x_d, h_pos;
  logic [YW-1:0] pix_y_q, pix_y_d, v_pos;
  logic [1:0]    phase_q, phase_d;
  logic          running, h_last, v_last, h_sync, v_sync, h_active, v_active;
  logic          h_wrap, eof, de_d;

  timing_cnt #(.DISP(H_DISP), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_hcnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (running),
    .clr_i    (!running),
    .pos_o    (h_pos),
    .last_o   (h_last),
    .sync_o   (h_sync),
    .active_o (h_active)
  );

  timing_cnt #(.DISP(V_DISP), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_vcnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (h_wrap),
    .clr_i    (!running),
    .pos_o    (v_pos),
    .last_o   (v_last),
    .sync_o   (v_sync),
    .active_o (v_active)
  );

  assign running  = (state_q != IDLE);
  assign h_wrap   = running && h_last;
  assign eof      = h_wrap && v_last;
  assign fcnt_inc = fcnt_q + 16'd1;
  assign de_d     = h_active && v_active;
  assign pix_x_d  = de_d ? h_pos : '0;
  assign pix_y_d  = de_d ? v_pos : '0;
  assign phase_d  = de_d ? bayer_phase_of(v_pos[0], h_pos[0]) : 2'b00;

  // busy follows the next state so it rises with RUN and drops right after the final EOF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      fcnt_q       <= '0;
      frame_num_q  <= '0;
      frame_done_q <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      phase_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl_io.start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            fcnt_q      <= '0;
            frame_num_q <= ctrl_io.frame_num;
          end
        end
        RUN: begin
          if (eof) begin
            fcnt_q <= fcnt_inc;
            if (((frame_num_q != 16'd0) && (fcnt_inc == frame_num_q)) || ctrl_io.stop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (ctrl_io.stop) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (eof) begin
            fcnt_q  <= fcnt_inc;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (running) begin
        frame_done_q <= eof;
        hsync_q      <= h_sync;
        vsync_q      <= v_sync;
        de_q         <= de_d;
        pix_x_q      <= pix_x_d;
        pix_y_q      <= pix_y_d;
        phase_q      <= phase_d;
      end else begin
        frame_done_q <= 1'b0;
        hsync_q      <= 1'b0;
        vsync_q      <= 1'b0;
        de_q         <= 1'b0;
        pix_x_q      <= '0;
        pix_y_q      <= '0;
        phase_q      <= '0;
      end
    end
  end

  assign ctrl_io.busy        = busy_q;
  assign ctrl_io.frame_done  = frame_done_q;
  assign ctrl_io.hsync       = hsync_q;
  assign ctrl_io.vsync       = vsync_q;
  assign ctrl_io.de          = de_q;
  assign ctrl_io.pix_x       = pix_x_q;
  assign ctrl_io.pix_y       = pix_y_q;
  assign ctrl_io.bayer_phase = phase_q;

`ifdef DEMOSAIC_FRAME_CTRL_STATS_EN
  logic [15:0] line_cnt_q;

  // Active lines are counted at the end of each active line since the last start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt_q <= '0;
    end else if ((state_q == IDLE) && ctrl_io.start) begin
      line_cnt_q <= '0;
    end else if (h_wrap && v_active) begin
      line_cnt_q <= line_cnt_q + 16'd1;
    end
  end

  assign ctrl_io.frame_cnt = fcnt_q;
  assign ctrl_io.line_cnt  = line_cnt_q;
`endif

endmodule

// File: doc/demosaic_frame_ctrl.md
# demosaic_frame_ctrl

Frame sequencer for the demosaic simulation chain. It generates the raster timing that drives the Bayer source and `bayer2rgb`: `hsync`, `vsync`, `de`, pixel coordinates and the CFA phase of each pixel. It runs, stops and counts frames under a start/stop pulse interface, so a bench or host can request a single frame, N frames or free-run operation.

## Interface
- `H_DISP`, 640, active pixels per line
- `V_DISP`, 480, active lines per frame
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch, in clocks
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins sequencing
- `stop`  in  1  single-cycle pulse that ends sequencing after the current frame
- `frame_num`  in  16  frames to run; 0 means free-run
- `busy`  out  1  high in RUN and DRAIN
- `frame_done`  out  1  one-cycle pulse on the last clock of each frame
- `hsync` / `vsync` / `de`  out  1 each  active-high sync and data enable
- `pix_x`  out  `$clog2(H_DISP)`  column, valid while `de`
- `pix_y`  out  `$clog2(V_DISP)`  row, valid while `de`
- `bayer_phase`  out  2  `{pix_y[0], pix_x[0]}`, valid while `de`

## Operation
- Totals: H_TOT = H_DISP+H_FP+H_SYNC+H_BP and V_TOT = V_DISP+V_FP+V_SYNC+V_BP.
- Counters: `hcnt` runs 0..H_TOT-1. `vcnt` increments when `hcnt` wraps and itself wraps at V_TOT. End-of-frame (EOF) is `hcnt==H_TOT-1 && vcnt==V_TOT-1`.
- Regions, in counter order: active, then front porch, then sync, then back porch.
  - `hsync` = `hcnt` in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC).
  - `vsync` uses the same rule applied to `vcnt`.
  - `de` = `hcnt<H_DISP && vcnt<V_DISP`.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters are held at 0 and all outputs are 0. `start` → RUN with counters at 0, and the frame counter `fcnt` cleared.
  - RUN: the counters advance every clock.
    - At EOF, `fcnt` increments.
    - If `frame_num!=0` and `fcnt+1==frame_num`, go to IDLE.
    - `stop` → DRAIN.
    - `stop` coinciding with EOF → IDLE directly.
  - DRAIN: the counters keep running. EOF → IDLE.
- `start` is ignored outside IDLE. `stop` is ignored in IDLE and DRAIN. If `start` and `stop` assert together in IDLE, `start` wins.
- `frame_num` is sampled on `start`. Changes during RUN have no effect.
- `fcnt` is 16 bits and wraps silently in free-run.
- In-flight frames are never truncated. The only way to abort a frame is `rst`.

## Timing
- Outputs are registered and lag the counter state by 1 clock.
- First frame: `start` at cycle T means the counters are 0 from T+1, so the first `de`/`hsync` values appear at T+2.
- `frame_done` asserts on the output cycle that corresponds to EOF.
- `busy` rises at T+1 and falls on the clock after the final EOF.
- Reset: asynchronous assert; release is used synchronously. State = IDLE, all counters 0, all outputs 0.
- Reset mid-frame: outputs drop to 0 immediately, with no partial-frame completion.

## Configuration
- Macro: `DEMOSAIC_FRAME_CTRL_STATS_EN`.
- When defined, adds two outputs:
  - `frame_cnt` [15:0]: mirror of `fcnt`.
  - `line_cnt` [15:0]: counts active lines since `start`, cleared on `start`.
- When undefined, those ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `demosaic_pkg` holds:
  - state enum `frame_state_t` (IDLE, RUN, DRAIN)
  - the default VGA 640x480 timing constants
  - `BAYER_RGGB`-style phase encodings, shared with `bayer2rgb`
- One sub-module: `timing_cnt`, a parameterised wrap counter with region compare.
  - Instantiated twice: horizontal, and vertical (enabled on horizontal wrap).
  - Returns count, sync and active flags.
- The FSM, frame counter and output registers live in the top of this block.

## Test plan
- Bench parameters: H_DISP=8, V_DISP=4, H porches 2/2/2, V porches 1/1/1, giving H_TOT=14, V_TOT=7, 98 clocks per frame.
- Reset idle: hold `rst` for 3 clocks, then keep `start` low for 50 clocks → `busy`/`de`/`hsync`/`vsync` stay 0.
- Single frame: `frame_num`=1, `start` at T → exactly 32 `de` cycles, `pix_x` 0..7 per line, `bayer_phase` sequence 0,1,0,1… then 2,3…, one `frame_done`, `busy` low from T+99.
- Multi-frame with stop: `frame_num`=0, `stop` mid-frame 2 → frame 2 completes fully, 2 `frame_done` pulses, then IDLE.
- Corner events:
  - `stop` on the EOF cycle → IDLE with no extra frame.
  - `start`+`stop` together in IDLE → RUN.
  - `start` during RUN → ignored, so the frame count is unchanged.
- Reset mid-frame: `rst` pulsed at cycle 40 of frame 1 → all outputs 0 in the same cycle; a subsequent `start` gives a clean frame from (0,0).
- Macro on: 3-frame run → `frame_cnt`=3, `line_cnt`=12.
